multicycle_control_unit: RTL and testbench

Multi-cycle control FSM for the RV32I datapath that drives the existing combinational ALU and the surrounding muxes, register file and memories. It sequences each instruction through fetch, decode, execute, memory and writeback states. It generates the 4-bit ALU operation code consumed by the ALU, and handshakes with instruction and data memories that may take a variable number of cycles.

---
 rtl/multicycle_control_unit.sv | 229 ++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: FETCH -> DECODE -> EXECUTE -> [MEMORY] -> [WRITEBACK].
// Drives ALU op/operand selects, register-file/memory strobes and PC update.
// Instruction and data memory handshakes are bounded by MEM_TIMEOUT wait cycles.
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN. When defined, a non-RV32I opcode in DECODE
// sets Fault and halts. When undefined, that opcode executes as a NOP (PC+4).
module multicycle_control_unit #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Inst,
  input  logic        IMReady,
  input  logic        DMReady,
  input  logic        BrTaken,
  output logic        IMReq,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        PCSrc,
  output logic [1:0]  ALUASrc,
  output logic        ALUBSrc,
  output logic [3:0]  ALUOp,
  output logic [2:0]  ImmSrc,
  output logic        RUWr,
  output logic [1:0]  RUDataWrSrc,
  output logic        DMRd,
  output logic        DMWr,
  output logic        Fault,
  output logic [2:0]  State
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_TIMEOUT - 1);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd7
  } state_t;

  state_t        state, state_nx;
  logic [6:0]    opcode;
  logic [2:0]    funct3;
  logic          f7b5;
  logic [CW-1:0] wait_cnt, wait_nx;
  logic          fault_set;
  logic          is_load;

  logic [3:0]    alu_op_dec;
  logic [1:0]    asrc_dec;
  logic          bsrc_dec;
  logic [2:0]    imm_dec;
  logic          legal;

  // Only opcode, funct3 and funct7[5] steer control; the rest of the word is datapath-only.
  logic unused_inst;
  assign unused_inst = ^{Inst[31], Inst[29:15], Inst[11:7]};

  assign is_load = (opcode == OP_LOAD);

  // State, decode latches, wait counter and sticky fault.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_FETCH;
      opcode   <= '0;
      funct3   <= '0;
      f7b5     <= 1'b0;
      wait_cnt <= '0;
      Fault    <= 1'b0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_nx;
      if (fault_set) Fault <= 1'b1;
      if (state == S_FETCH && IMReady) begin
        opcode <= Inst[6:0];
        funct3 <= Inst[14:12];
        f7b5   <= Inst[30];
      end
    end
  end

  // Per-class ALU control and immediate format from the latched instruction fields.
  always_comb begin
    alu_op_dec = 4'b0000;
    asrc_dec   = 2'b00;
    bsrc_dec   = 1'b1;
    imm_dec    = 3'b000;
    legal      = 1'b1;
    case (opcode)
      OP_R:      begin alu_op_dec = {f7b5, funct3}; bsrc_dec = 1'b0; end
      OP_IMM:    alu_op_dec = {(funct3 == 3'b101) ? f7b5 : 1'b0, funct3};
      OP_LOAD:   ;
      OP_STORE:  imm_dec = 3'b001;
      OP_LUI:    begin asrc_dec = 2'b10; imm_dec = 3'b101; end
      OP_AUIPC:  begin asrc_dec = 2'b01; imm_dec = 3'b101; end
      OP_BRANCH: begin asrc_dec = 2'b01; imm_dec = 3'b010; end
      OP_JAL:    begin asrc_dec = 2'b01; imm_dec = 3'b110; end
      OP_JALR:   ;
      OP_FENCE, OP_SYSTEM: bsrc_dec = 1'b0;
      default:   begin bsrc_dec = 1'b0; legal = 1'b0; end
    endcase
  end

  // Next-state, wait counter and output strobes. ALU controls stay asserted past EXECUTE
  // so the memory address and writeback result remain stable while waiting.
  always_comb begin
    state_nx    = state;
    wait_nx     = wait_cnt;
    fault_set   = 1'b0;
    IMReq       = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCSrc       = 1'b0;
    ALUASrc     = 2'b00;
    ALUBSrc     = 1'b0;
    ALUOp       = 4'b0000;
    ImmSrc      = 3'b000;
    RUWr        = 1'b0;
    RUDataWrSrc = 2'b00;
    DMRd        = 1'b0;
    DMWr        = 1'b0;
    State       = state;
    case (state)
      S_FETCH: begin
        IMReq = 1'b1;
        if (IMReady) begin
          IRWrite  = 1'b1;
          state_nx = S_DECODE;
          wait_nx  = '0;
        end else if (wait_cnt == WAIT_LAST) begin
          fault_set = 1'b1;
          state_nx  = S_HALT;
          wait_nx   = '0;
        end else begin
          wait_nx = wait_cnt + CW'(1);
        end
      end
      S_DECODE: begin
        ImmSrc = imm_dec;
`ifdef CTRL_ILLEGAL_TRAP_EN
        if (!legal) begin
          fault_set = 1'b1;
          state_nx  = S_HALT;
        end else begin
          state_nx = S_EXECUTE;
        end
`else
        state_nx = S_EXECUTE;
`endif
      end
      S_EXECUTE: begin
        ImmSrc  = imm_dec;
        ALUOp   = alu_op_dec;
        ALUASrc = asrc_dec;
        ALUBSrc = bsrc_dec;
        case (opcode)
          OP_LOAD, OP_STORE: state_nx = S_MEMORY;
          OP_R, OP_IMM, OP_LUI, OP_AUIPC: state_nx = S_WRITEBACK;
          OP_BRANCH: begin
            PCWrite  = 1'b1;
            PCSrc    = BrTaken;
            state_nx = S_FETCH;
          end
          OP_JAL, OP_JALR: begin
            RUWr        = 1'b1;
            RUDataWrSrc = 2'b10;
            PCWrite     = 1'b1;
            PCSrc       = 1'b1;
            state_nx    = S_FETCH;
          end
          default: begin
            PCWrite  = 1'b1;
            state_nx = S_FETCH;
          end
        endcase
      end
      S_MEMORY: begin
        ImmSrc  = imm_dec;
        ALUOp   = alu_op_dec;
        ALUASrc = asrc_dec;
        ALUBSrc = bsrc_dec;
        DMRd    = is_load;
        DMWr    = !is_load;
        if (DMReady) begin
          wait_nx = '0;
          if (is_load) begin
            state_nx = S_WRITEBACK;
          end else begin
            PCWrite  = 1'b1;
            state_nx = S_FETCH;
          end
        end else if (wait_cnt == WAIT_LAST) begin
          fault_set = 1'b1;
          state_nx  = S_HALT;
          wait_nx   = '0;
        end else begin
          wait_nx = wait_cnt + CW'(1);
        end
      end
      S_WRITEBACK: begin
        ImmSrc      = imm_dec;
        ALUOp       = alu_op_dec;
        ALUASrc     = asrc_dec;
        ALUBSrc     = bsrc_dec;
        RUWr        = 1'b1;
        RUDataWrSrc = is_load ? 2'b01 : 2'b00;
        PCWrite     = 1'b1;
        state_nx    = S_FETCH;
      end
      S_HALT: ;
      default: state_nx = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: directed scenarios plus randomized
// instructions compared against a per-class behavioural table (latency, strobes, selects).
module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] Inst;
  logic        IMReady, DMReady, BrTaken;
  logic        IMReq, IRWrite, PCWrite, PCSrc, ALUBSrc, RUWr, DMRd, DMWr, Fault;
  logic [1:0]  ALUASrc, RUDataWrSrc;
  logic [3:0]  ALUOp;
  logic [2:0]  ImmSrc, State;

  multicycle_control_unit #(.MEM_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .Inst(Inst), .IMReady(IMReady), .DMReady(DMReady),
    .BrTaken(BrTaken), .IMReq(IMReq), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .PCSrc(PCSrc), .ALUASrc(ALUASrc), .ALUBSrc(ALUBSrc), .ALUOp(ALUOp),
    .ImmSrc(ImmSrc), .RUWr(RUWr), .RUDataWrSrc(RUDataWrSrc), .DMRd(DMRd),
    .DMWr(DMWr), .Fault(Fault), .State(State)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // observed and expected per-instruction summaries
  int          o_lat, o_ruwr_n, o_pcw_n, o_dmrd_n, o_dmwr_n, o_irw_n;
  logic [3:0]  o_aluop;
  logic [1:0]  o_asrc, o_wrsrc;
  logic        o_bsrc, o_pcsrc, o_fault;
  logic [2:0]  o_imm, o_end;
  logic [31:0] o_path;

  int          e_lat, e_ruwr_n, e_pcw_n, e_dmrd_n, e_dmwr_n, e_irw_n;
  logic [3:0]  e_aluop;
  logic [1:0]  e_asrc, e_wrsrc;
  logic        e_bsrc, e_pcsrc, e_fault;
  logic [2:0]  e_imm, e_end;
  logic [31:0] e_path;

  function automatic logic [31:0] make_inst(input logic [6:0] op, input logic [2:0] f3,
                                            input logic b30);
    return {1'b0, b30, 5'($urandom), 5'($urandom), 5'($urandom), f3, 5'($urandom), op};
  endfunction

  // Reference model: instruction class table from the architectural rules.
  task automatic model(input logic [31:0] inst, input int imw, input int dmw, input logic br);
    logic [6:0] op;
    logic [2:0] f3;
    op = inst[6:0];
    f3 = inst[14:12];
    e_aluop = 4'h0; e_asrc = 2'b00; e_bsrc = 1'b1; e_imm = 3'b000;
    e_ruwr_n = 0; e_wrsrc = 2'b00; e_pcw_n = 1; e_pcsrc = 1'b0;
    e_dmrd_n = 0; e_dmwr_n = 0; e_irw_n = 1; e_fault = 1'b0; e_end = 3'd0;
    case (op)
      7'b0110011: begin e_lat = 4; e_path = 32'h0124; e_bsrc = 1'b0;
                        e_aluop = {inst[30], f3}; e_ruwr_n = 1; end
      7'b0010011: begin e_lat = 4; e_path = 32'h0124; e_ruwr_n = 1;
                        e_aluop = {(f3 == 3'd5) ? inst[30] : 1'b0, f3}; end
      7'b0000011: begin e_lat = 5 + dmw; e_path = 32'h01234; e_ruwr_n = 1;
                        e_wrsrc = 2'b01; e_dmrd_n = dmw + 1; end
      7'b0100011: begin e_lat = 4 + dmw; e_path = 32'h0123; e_imm = 3'b001;
                        e_dmwr_n = dmw + 1; end
      7'b0110111: begin e_lat = 4; e_path = 32'h0124; e_asrc = 2'b10; e_imm = 3'b101;
                        e_ruwr_n = 1; end
      7'b0010111: begin e_lat = 4; e_path = 32'h0124; e_asrc = 2'b01; e_imm = 3'b101;
                        e_ruwr_n = 1; end
      7'b1100011: begin e_lat = 3; e_path = 32'h012; e_asrc = 2'b01; e_imm = 3'b010;
                        e_pcsrc = br; end
      7'b1101111: begin e_lat = 3; e_path = 32'h012; e_asrc = 2'b01; e_imm = 3'b110;
                        e_ruwr_n = 1; e_wrsrc = 2'b10; e_pcsrc = 1'b1; end
      7'b1100111: begin e_lat = 3; e_path = 32'h012; e_ruwr_n = 1; e_wrsrc = 2'b10;
                        e_pcsrc = 1'b1; end
      7'b0001111, 7'b1110011: begin e_lat = 3; e_path = 32'h012; e_bsrc = 1'b0; end
      default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
        e_lat = 2; e_path = 32'h01; e_pcw_n = 0; e_fault = 1'b1; e_end = 3'd7;
`else
        e_lat = 3; e_path = 32'h012; e_bsrc = 1'b0;
`endif
      end
    endcase
    e_lat = e_lat + imw;
  endtask

  // Drives one instruction with the given wait counts and records what the DUT did.
  task automatic run_instr(input logic [31:0] inst, input int imw, input int dmw,
                           input logic br);
    int fw, mw;
    logic [2:0] last;
    logic left;
    fw = 0; mw = 0; last = 3'd6; left = 1'b0;
    o_lat = 0; o_ruwr_n = 0; o_pcw_n = 0; o_dmrd_n = 0; o_dmwr_n = 0; o_irw_n = 0;
    o_aluop = 4'hx; o_asrc = 2'bxx; o_bsrc = 1'bx; o_imm = 3'bxxx;
    o_wrsrc = 2'b00; o_pcsrc = 1'b0; o_path = 32'h0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      Inst = inst; BrTaken = br;
      IMReady = (State == 3'd0) && (fw >= imw);
      DMReady = (State == 3'd3) && (mw >= dmw);
      #1;
      o_lat++;
      if (State != last) begin o_path = {o_path[27:0], 1'b0, State}; last = State; end
      if (State != 3'd0) left = 1'b1;
      if (State == 3'd1) o_imm = ImmSrc;
      if (State == 3'd2) begin o_aluop = ALUOp; o_asrc = ALUASrc; o_bsrc = ALUBSrc; end
      if (RUWr) begin o_ruwr_n++; o_wrsrc = RUDataWrSrc; end
      if (PCWrite) begin o_pcw_n++; o_pcsrc = PCSrc; end
      if (DMRd) o_dmrd_n++;
      if (DMWr) o_dmwr_n++;
      if (IRWrite) o_irw_n++;
      if (State == 3'd0) fw++;
      if (State == 3'd3) mw++;
      @(posedge clk); #1;
      if ((left && State == 3'd0) || State == 3'd7) break;
    end
    IMReady = 1'b0; DMReady = 1'b0;
    o_end = State; o_fault = Fault;
  endtask

  task automatic do_reset();
    rst = 1'b1; IMReady = 1'b0; DMReady = 1'b0; BrTaken = 1'b0; Inst = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; IMReady = 1'b0; DMReady = 1'b0; BrTaken = 1'b0; Inst = 32'h0;
    #12;
    checks++; if (State !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", State); end
    checks++; if (IMReq !== 1'b1) begin errors++; $display("FAIL reset_imreq got %b exp 1", IMReq); end
    checks++; if ({IRWrite, PCWrite, PCSrc, ALUASrc, ALUBSrc, ALUOp, ImmSrc, RUWr, RUDataWrSrc,
                   DMRd, DMWr, Fault} !== '0) begin
      errors++; $display("FAIL reset_outputs got nonzero strobes exp all 0");
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_alu_ops();
    logic [31:0] insts [5];
    logic [3:0]  exp_op [5];
    insts[0] = make_inst(7'b0110011, 3'b000, 1'b0); exp_op[0] = 4'b0000; // add
    insts[1] = make_inst(7'b0110011, 3'b000, 1'b1); exp_op[1] = 4'b1000; // sub
    insts[2] = make_inst(7'b0010011, 3'b101, 1'b1); exp_op[2] = 4'b1101; // srai
    insts[3] = make_inst(7'b0010011, 3'b001, 1'b0); exp_op[3] = 4'b0001; // slli
    insts[4] = make_inst(7'b0010011, 3'b100, 1'b1); exp_op[4] = 4'b0100; // xori, imm bit30 set
    for (int i = 0; i < 5; i++) begin
      run_instr(insts[i], 0, 0, 1'b0);
      checks++; if (o_aluop !== exp_op[i]) begin errors++; $display("FAIL aluop[%0d] got %b exp %b", i, o_aluop, exp_op[i]); end
      checks++; if (o_path !== 32'h0124) begin errors++; $display("FAIL alu_path[%0d] got %h exp 0124", i, o_path); end
      checks++; if (o_lat !== 4) begin errors++; $display("FAIL alu_lat[%0d] got %0d exp 4", i, o_lat); end
      checks++; if (o_ruwr_n !== 1 || o_pcw_n !== 1 || o_pcsrc !== 1'b0) begin
        errors++; $display("FAIL alu_wb[%0d] got ruwr=%0d pcw=%0d pcsrc=%b exp 1 1 0", i, o_ruwr_n, o_pcw_n, o_pcsrc);
      end
    end
  endtask

  task automatic test_load_wait();
    run_instr(make_inst(7'b0000011, 3'b010, 1'b0), 0, 3, 1'b0);
    checks++; if (o_dmrd_n !== 4) begin errors++; $display("FAIL lw_dmrd got %0d exp 4", o_dmrd_n); end
    checks++; if (o_wrsrc !== 2'b01) begin errors++; $display("FAIL lw_wrsrc got %b exp 01", o_wrsrc); end
    checks++; if (o_lat !== 8) begin errors++; $display("FAIL lw_lat got %0d exp 8", o_lat); end
  endtask

  task automatic test_branch();
    for (int t = 1; t >= 0; t--) begin
      run_instr(make_inst(7'b1100011, 3'b000, 1'b0), 0, 0, 1'(t));
      checks++; if (o_pcsrc !== 1'(t) || o_pcw_n !== 1) begin
        errors++; $display("FAIL beq_pc[%0d] got pcsrc=%b pcw=%0d exp %0d 1", t, o_pcsrc, o_pcw_n, t);
      end
      checks++; if (o_lat !== 3 || o_end !== 3'd0) begin
        errors++; $display("FAIL beq_flow[%0d] got lat=%0d end=%0d exp 3 0", t, o_lat, o_end);
      end
    end
  endtask

  task automatic test_ready_at_limit();
    run_instr(make_inst(7'b0110011, 3'b000, 1'b0), 15, 0, 1'b0);
    checks++; if (o_fault !== 1'b0 || o_lat !== 19) begin
      errors++; $display("FAIL ready_at_limit got fault=%b lat=%0d exp 0 19", o_fault, o_lat);
    end
  endtask

  task automatic test_timeout();
    int bad;
    do_reset();
    bad = 0;
    for (int k = 1; k <= 16; k++) begin
      #1;
      if (State !== 3'd0 || Fault !== 1'b0) bad++;
      @(negedge clk);
    end
    #1;
    checks++; if (bad !== 0) begin errors++; $display("FAIL timeout_wait got %0d bad cycles exp 0", bad); end
    checks++; if (State !== 3'd7 || Fault !== 1'b1) begin
      errors++; $display("FAIL timeout_halt got state=%0d fault=%b exp 7 1", State, Fault);
    end
    IMReady = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (State !== 3'd7 || IMReq !== 1'b0 || IRWrite !== 1'b0) begin
      errors++; $display("FAIL halt_sticky got state=%0d imreq=%b exp 7 0", State, IMReq);
    end
    do_reset();
    #1;
    checks++; if (State !== 3'd0 || Fault !== 1'b0) begin
      errors++; $display("FAIL timeout_reset got state=%0d fault=%b exp 0 0", State, Fault);
    end
    // data memory that never answers
    run_instr(make_inst(7'b0100011, 3'b010, 1'b0), 0, 100, 1'b0);
    checks++; if (o_end !== 3'd7 || o_fault !== 1'b1 || o_dmwr_n !== 16 || o_pcw_n !== 0) begin
      errors++; $display("FAIL dm_timeout got end=%0d fault=%b dmwr=%0d pcw=%0d exp 7 1 16 0", o_end, o_fault, o_dmwr_n, o_pcw_n);
    end
    do_reset();
  endtask

  task automatic test_mid_reset();
    int guard;
    guard = 0;
    Inst = make_inst(7'b0000011, 3'b010, 1'b0);
    while (guard < 20) begin
      @(negedge clk);
      IMReady = (State == 3'd0); DMReady = 1'b0;
      #1;
      if (State == 3'd3) break;
      guard++;
    end
    checks++; if (State !== 3'd3 || DMRd !== 1'b1) begin
      errors++; $display("FAIL midrst_reach got state=%0d dmrd=%b exp 3 1", State, DMRd);
    end
    #1 rst = 1'b1;
    #1;
    checks++; if (State !== 3'd0 || DMRd !== 1'b0 || RUWr !== 1'b0 || IMReq !== 1'b1) begin
      errors++; $display("FAIL midrst_abort got state=%0d dmrd=%b ruwr=%b exp 0 0 0", State, DMRd, RUWr);
    end
    @(negedge clk); rst = 1'b0; IMReady = 1'b0;
  endtask

  task automatic test_illegal();
    model({25'h0, 7'b1111111}, 0, 0, 1'b0);
    run_instr({25'h0, 7'b1111111}, 0, 0, 1'b0);
    checks++; if (o_fault !== e_fault || o_end !== e_end) begin
      errors++; $display("FAIL illegal_fault got fault=%b end=%0d exp %b %0d", o_fault, o_end, e_fault, e_end);
    end
    checks++; if (o_pcw_n !== e_pcw_n || o_pcsrc !== 1'b0 || o_ruwr_n !== 0 || o_dmwr_n !== 0) begin
      errors++; $display("FAIL illegal_strobes got pcw=%0d ruwr=%0d dmwr=%0d exp %0d 0 0", o_pcw_n, o_ruwr_n, o_dmwr_n, e_pcw_n);
    end
    checks++; if (o_path !== e_path) begin errors++; $display("FAIL illegal_path got %h exp %h", o_path, e_path); end
    do_reset();
  endtask

  task automatic test_random();
    logic [6:0] ops [10];
    logic [31:0] inst;
    int imw, dmw;
    logic br;
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b0110111,
            7'b0010111, 7'b1100011, 7'b1101111, 7'b1100111, 7'b0001111};
    for (int n = 0; n < 40; n++) begin
      inst = make_inst(ops[$urandom_range(0, 9)], 3'($urandom), 1'($urandom));
      imw = $urandom_range(0, 3); dmw = $urandom_range(0, 3); br = 1'($urandom);
      model(inst, imw, dmw, br);
      run_instr(inst, imw, dmw, br);
      checks++; if (o_lat !== e_lat) begin errors++; $display("FAIL rnd_lat[%0d] op=%b got %0d exp %0d", n, inst[6:0], o_lat, e_lat); end
      checks++; if (o_path !== e_path) begin errors++; $display("FAIL rnd_path[%0d] got %h exp %h", n, o_path, e_path); end
      checks++; if (o_aluop !== e_aluop) begin errors++; $display("FAIL rnd_aluop[%0d] got %b exp %b", n, o_aluop, e_aluop); end
      checks++; if (o_asrc !== e_asrc || o_bsrc !== e_bsrc) begin
        errors++; $display("FAIL rnd_src[%0d] got %b/%b exp %b/%b", n, o_asrc, o_bsrc, e_asrc, e_bsrc);
      end
      checks++; if (o_imm !== e_imm) begin errors++; $display("FAIL rnd_imm[%0d] got %b exp %b", n, o_imm, e_imm); end
      checks++; if (o_ruwr_n !== e_ruwr_n || o_wrsrc !== e_wrsrc) begin
        errors++; $display("FAIL rnd_ruwr[%0d] got %0d/%b exp %0d/%b", n, o_ruwr_n, o_wrsrc, e_ruwr_n, e_wrsrc);
      end
      checks++; if (o_pcw_n !== e_pcw_n || o_pcsrc !== e_pcsrc) begin
        errors++; $display("FAIL rnd_pc[%0d] got %0d/%b exp %0d/%b", n, o_pcw_n, o_pcsrc, e_pcw_n, e_pcsrc);
      end
      checks++; if (o_dmrd_n !== e_dmrd_n || o_dmwr_n !== e_dmwr_n) begin
        errors++; $display("FAIL rnd_dm[%0d] got %0d/%0d exp %0d/%0d", n, o_dmrd_n, o_dmwr_n, e_dmrd_n, e_dmwr_n);
      end
      checks++; if (o_irw_n !== e_irw_n || o_fault !== e_fault) begin
        errors++; $display("FAIL rnd_irw[%0d] got %0d/%b exp %0d/%b", n, o_irw_n, o_fault, e_irw_n, e_fault);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_load_wait();
    test_branch();
    test_ready_at_limit();
    test_random();
    test_mid_reset();
    test_illegal();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
